ex_mem_muldiv_stage: RTL and testbench



---
 rtl/ex_mem_muldiv_stage.sv | 191 +++++++++++++++++++
 tb/tb_ex_mem_muldiv_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_muldiv_stage.sv
// EX/MEM pipeline register with an iterative multiply/divide unit and HI/LO registers.
// Muldiv ops run in the background; HI/LO readers and new muldiv ops stall while it is busy.
module ex_mem_muldiv_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_e,
    input  logic         mem_read_e,
    input  logic         mem_write_e,
    input  logic         mem_to_reg_e,
    input  logic         reg_write_e,
    input  logic         link_en_e,
    input  logic [2:0]   md_op_e,
    input  logic [W-1:0] rs_val_e,
    input  logic [W-1:0] rt_val_e,
    input  logic [W-1:0] alu_result_e,
    input  logic [W-1:0] write_data_e,
    input  logic [4:0]   dest_reg_e,
    input  logic [W-1:0] link_data_e,
    output logic         mem_read_m,
    output logic         mem_write_m,
    output logic         mem_to_reg_m,
    output logic         reg_write_m,
    output logic         link_en_m,
    output logic [W-1:0] alu_result_m,
    output logic [W-1:0] write_data_m,
    output logic [W-1:0] link_data_m,
    output logic [4:0]   dest_reg_m,
    output logic         stall_o,
    output logic         md_busy_o
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic           is_div, neg_lo, neg_hi, div_zero;
    logic [W-1:0]   opb, hi_acc, lo_acc, hi, lo;

    logic           is_md_op, is_md_any, is_mfhi, is_mflo, is_signed, is_div_op;
    logic           start, load, last_iter;
    logic           rs_neg, rt_neg;
    logic [W-1:0]   rs_abs, rt_abs;
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, dz_hi;

    assign is_md_op  = (md_op_e >= 3'd1) && (md_op_e <= 3'd4);
    assign is_md_any = (md_op_e >= 3'd1) && (md_op_e <= 3'd6);
    assign is_mfhi   = (md_op_e == 3'd5);
    assign is_mflo   = (md_op_e == 3'd6);
    assign is_signed = (md_op_e == 3'd1) || (md_op_e == 3'd3);
    assign is_div_op = (md_op_e == 3'd3) || (md_op_e == 3'd4);

    assign md_busy_o = (state != IDLE);
    assign stall_o   = valid_e && is_md_any && (state != IDLE);
    assign start     = valid_e && is_md_op && !stall_o && (state == IDLE);
    assign load      = valid_e && !stall_o;
    assign last_iter = (cnt == CW'(W - 1));

    // Signed ops iterate on magnitudes; the signs are reapplied in FIX.
    assign rs_neg = is_signed && rs_val_e[W-1];
    assign rt_neg = is_signed && rt_val_e[W-1];
    assign rs_abs = rs_neg ? (~rs_val_e + 1'b1) : rs_val_e;
    assign rt_abs = rt_neg ? (~rt_val_e + 1'b1) : rt_val_e;

    assign mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
    assign div_shift = {hi_acc, lo_acc[W-1]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_diff  = div_shift[W-1:0] - opb;

    assign prod     = {hi_acc, lo_acc};
    assign prod_fix = neg_lo ? (~prod + 1'b1) : prod;
    assign quo_fix  = neg_lo ? (~lo_acc + 1'b1) : lo_acc;
    assign rem_fix  = neg_hi ? (~hi_acc + 1'b1) : hi_acc;
    assign dz_hi    = neg_hi ? (~lo_acc + 1'b1) : lo_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = BUSY;
            BUSY: if (last_iter) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // With a zero divisor the dividend magnitude is kept in lo_acc so FIX can return it in HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            opb      <= '0;
            hi_acc   <= '0;
            lo_acc   <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        is_div   <= is_div_op;
                        neg_lo   <= rs_neg ^ rt_neg;
                        neg_hi   <= rs_neg;
                        div_zero <= (rt_val_e == '0);
                        hi_acc   <= '0;
                        lo_acc   <= is_div_op ? rs_abs : rt_abs;
                        opb      <= is_div_op ? rt_abs : rs_abs;
                    end
                end
                BUSY: begin
                    cnt <= last_iter ? '0 : cnt + 1'b1;
                    if (!is_div) begin
                        hi_acc <= mul_sum[W:1];
                        lo_acc <= {mul_sum[0], lo_acc[W-1:1]};
                    end else if (!div_zero) begin
                        hi_acc <= div_ge ? div_diff : div_shift[W-1:0];
                        lo_acc <= {lo_acc[W-2:0], div_ge};
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end else if (div_zero) begin
                        hi <= dz_hi;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    // EX/MEM boundary: stalled or empty slots become bubbles; muldiv ops never write the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_m   <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            reg_write_m  <= 1'b0;
            link_en_m    <= 1'b0;
            alu_result_m <= '0;
            write_data_m <= '0;
            link_data_m  <= '0;
            dest_reg_m   <= '0;
        end else if (!load) begin
            mem_read_m   <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            reg_write_m  <= 1'b0;
            link_en_m    <= 1'b0;
            alu_result_m <= '0;
            write_data_m <= '0;
            link_data_m  <= '0;
            dest_reg_m   <= '0;
        end else begin
            mem_read_m   <= mem_read_e;
            mem_write_m  <= mem_write_e;
            mem_to_reg_m <= mem_to_reg_e;
            reg_write_m  <= reg_write_e && !is_md_op;
            link_en_m    <= link_en_e;
            alu_result_m <= is_mfhi ? hi : (is_mflo ? lo : alu_result_e);
            write_data_m <= write_data_e;
            link_data_m  <= link_data_e;
            dest_reg_m   <= dest_reg_e;
        end
    end

endmodule

// File: tb/tb_ex_mem_muldiv_stage.sv
// Randomized scoreboard bench for ex_mem_muldiv_stage against an arithmetic HI/LO reference model.
module tb_ex_mem_muldiv_stage;

    typedef struct packed {
        logic [4:0]  ctl;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] link;
        logic [4:0]  dest;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  ctl;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] link;
        logic [4:0]  dest;
    } instr_t;

    logic        clk, rst_n;
    logic        valid_e, mem_read_e, mem_write_e, mem_to_reg_e, reg_write_e, link_en_e;
    logic [2:0]  md_op_e;
    logic [31:0] rs_val_e, rt_val_e, alu_result_e, write_data_e, link_data_e;
    logic [4:0]  dest_reg_e;
    logic        mem_read_m, mem_write_m, mem_to_reg_m, reg_write_m, link_en_m;
    logic [31:0] alu_result_m, write_data_m, link_data_m;
    logic [4:0]  dest_reg_m;
    logic        stall_o, md_busy_o;

    int          n_checks = 0;
    int          n_fail = 0;
    exmem_t      exp_q[$];

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          busy_left;

    ex_mem_muldiv_stage #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_e(valid_e),
        .mem_read_e(mem_read_e), .mem_write_e(mem_write_e), .mem_to_reg_e(mem_to_reg_e),
        .reg_write_e(reg_write_e), .link_en_e(link_en_e), .md_op_e(md_op_e),
        .rs_val_e(rs_val_e), .rt_val_e(rt_val_e), .alu_result_e(alu_result_e),
        .write_data_e(write_data_e), .dest_reg_e(dest_reg_e), .link_data_e(link_data_e),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
        .reg_write_m(reg_write_m), .link_en_m(link_en_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .link_data_m(link_data_m), .dest_reg_m(dest_reg_m),
        .stall_o(stall_o), .md_busy_o(md_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from 64-bit integer arithmetic.
    task automatic refMuldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0;
        l = '0;
        case (op)
            3'd1: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    if (op == 3'd4) begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end
            end
            default: ;
        endcase
    endtask

    function automatic instr_t mkIdle();
        instr_t i;
        i.valid = 1'b0;
        i.ctl = 5'($urandom);
        i.op = 3'($urandom);
        i.rs = $urandom; i.rt = $urandom; i.alu = $urandom;
        i.wd = $urandom; i.link = $urandom; i.dest = 5'($urandom);
        return i;
    endfunction

    function automatic instr_t mkOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        instr_t i;
        i = mkIdle();
        i.valid = 1'b1;
        i.op = op;
        i.rs = a;
        i.rt = b;
        i.ctl = 5'b00010;
        return i;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Drives one instruction, holding it while the model says the front end is stalled.
    task automatic applyStimulus(input instr_t ins);
        int     guard;
        logic   st;
        exmem_t rec;
        guard = 0;
        do begin
            valid_e = ins.valid;
            {mem_read_e, mem_write_e, mem_to_reg_e, reg_write_e, link_en_e} = ins.ctl;
            md_op_e = ins.op;
            rs_val_e = ins.rs; rt_val_e = ins.rt; alu_result_e = ins.alu;
            write_data_e = ins.wd; link_data_e = ins.link; dest_reg_e = ins.dest;
            #1;
            st = ins.valid && (ins.op inside {[3'd1:3'd6]}) && (busy_left > 0);
            checkOutput("stall_o", 32'(stall_o), 32'(st));
            checkOutput("md_busy_o", 32'(md_busy_o), 32'(busy_left > 0));
            if (!ins.valid || st) begin
                rec = '0;
            end else begin
                rec.ctl = ins.ctl;
                if (ins.op inside {[3'd1:3'd4]}) rec.ctl[1] = 1'b0;
                rec.alu = (ins.op == 3'd5) ? m_hi : ((ins.op == 3'd6) ? m_lo : ins.alu);
                rec.wd = ins.wd;
                rec.link = ins.link;
                rec.dest = ins.dest;
            end
            @(posedge clk);
            exp_q.push_back(rec);
            if (busy_left > 0) begin
                if (busy_left == 1) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                busy_left--;
            end else if (ins.valid && (ins.op inside {[3'd1:3'd4]})) begin
                refMuldiv(ins.op, ins.rs, ins.rt, p_hi, p_lo);
                busy_left = 33;
            end
            #1;
            guard++;
        end while (st && guard < 200);
        if (st) checkOutput("stall_timeout", 32'(guard), 32'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(mkIdle());
    endtask

    task automatic drainBusy();
        int g;
        g = 0;
        while (busy_left > 0 && g < 40) begin
            applyStimulus(mkIdle());
            g++;
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_ctl"}, 32'({mem_read_m, mem_write_m, mem_to_reg_m, reg_write_m, link_en_m}), 32'd0);
        checkOutput({tag, "_alu"}, alu_result_m, 32'd0);
        checkOutput({tag, "_wd"}, write_data_m, 32'd0);
        checkOutput({tag, "_link"}, link_data_m, 32'd0);
        checkOutput({tag, "_dest"}, 32'(dest_reg_m), 32'd0);
        checkOutput({tag, "_busy"}, 32'(md_busy_o), 32'd0);
    endtask

    // Monitor: pops the expected EX/MEM contents for the edge just taken.
    always @(negedge clk) begin
        exmem_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("exmem_ctl", 32'({mem_read_m, mem_write_m, mem_to_reg_m, reg_write_m, link_en_m}), 32'(e.ctl));
            checkOutput("alu_result_m", alu_result_m, e.alu);
            checkOutput("write_data_m", write_data_m, e.wd);
            checkOutput("link_data_m", link_data_m, e.link);
            checkOutput("dest_reg_m", 32'(dest_reg_m), 32'(e.dest));
        end
    end

    logic [31:0] div_a[4] = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] div_b[4] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [2:0]  div_op[4] = '{3'd4, 3'd3, 3'd3, 3'd3};

    initial begin
        instr_t ins;
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; busy_left = 0;
        rst_n = 1'b0;
        ins = mkIdle();
        valid_e = 1'b0;
        {mem_read_e, mem_write_e, mem_to_reg_e, reg_write_e, link_en_e} = '0;
        md_op_e = '0; rs_val_e = '0; rt_val_e = '0; alu_result_e = '0;
        write_data_e = '0; link_data_e = '0; dest_reg_e = '0;
        #3;
        checkZeroOutputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Signed multiply, then read both halves once the unit is idle.
        applyStimulus(mkOp(3'd1, 32'd7, 32'hFFFF_FFFD));
        drainBusy();
        applyStimulus(mkOp(3'd6, 32'd0, 32'd0));
        applyStimulus(mkOp(3'd5, 32'd0, 32'd0));

        for (int k = 0; k < 4; k++) begin
            applyStimulus(mkOp(div_op[k], div_a[k], div_b[k]));
            drainBusy();
            applyStimulus(mkOp(3'd6, 32'd0, 32'd0));
            applyStimulus(mkOp(3'd5, 32'd0, 32'd0));
        end

        // Early MFLO stalls until the product is in LO.
        applyStimulus(mkOp(3'd2, 32'hDEAD_BEEF, 32'h1234_5678));
        idleCycles(2);
        applyStimulus(mkOp(3'd6, 32'd0, 32'd0));
        applyStimulus(mkOp(3'd5, 32'd0, 32'd0));

        // A load slips past a busy multiply; a second multiply waits.
        applyStimulus(mkOp(3'd1, 32'hFFFF_0000, 32'h0001_0001));
        ins = mkIdle();
        ins.valid = 1'b1; ins.op = 3'd0; ins.ctl = 5'b10110; ins.alu = 32'h100; ins.dest = 5'd8;
        applyStimulus(ins);
        applyStimulus(mkOp(3'd1, 32'h8000_0000, 32'h8000_0000));
        applyStimulus(mkOp(3'd5, 32'd0, 32'd0));
        applyStimulus(mkOp(3'd6, 32'd0, 32'd0));

        // Asynchronous reset in the middle of an operation.
        applyStimulus(mkOp(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
        idleCycles(11);
        #1 rst_n = 1'b0;
        #1;
        checkZeroOutputs("midreset");
        checkOutput("midreset_stall", 32'(stall_o), 32'd0);
        exp_q.delete();
        busy_left = 0; m_hi = '0; m_lo = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(mkOp(3'd5, 32'd0, 32'd0));

        for (int n = 0; n < 300; n++) begin
            ins = mkIdle();
            ins.valid = ($urandom_range(0, 3) != 0);
            ins.rs = pick();
            ins.rt = pick();
            applyStimulus(ins);
        end
        drainBusy();
        applyStimulus(mkOp(3'd5, 32'd0, 32'd0));
        applyStimulus(mkOp(3'd6, 32'd0, 32'd0));
        idleCycles(2);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
